// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: takes one decoded read/write command from the JTAG
// command decoder, runs a single AXI4-Lite transaction and returns the result.
// Optional build macro AXIL_CMD_MASTER_TIMEOUT_EN adds a per-phase watchdog
// that aborts a stalled transaction with rsp_resp=2'b10 and rsp_timeout=1.
module axil_cmd_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  // command channel
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response channel
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  // AXI4-Lite write address
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  // AXI4-Lite write data
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // AXI4-Lite read address
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  // AXI4-Lite read data
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned SW = AXI_DATA_WIDTH / 8;

  // Elaboration guard: the watchdog needs at least two cycles per phase.
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_range
    $error("axil_cmd_master: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } state_e;

  state_e                      state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]               wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic                        tmo_fire;

  // Next-state and registered-output logic for the single-transaction FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        // AW and W retire independently; each valid falls after its own handshake.
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          state_d     = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog abort wins over the wait states; it only fires when no handshake is in flight.
    if (tmo_fire) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_resp_d  = 2'b10;
      state_d     = ST_RSP;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] wait_q, wait_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          busy, progress;

  // Per-phase wait counter: cleared outside the wait states and on every handshake.
  always_comb begin
    busy     = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
               (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    progress = (awvalid_q && m_axi_awready) || (wvalid_q && m_axi_wready) ||
               (bready_q  && m_axi_bvalid)  || (arvalid_q && m_axi_arready) ||
               (rready_q  && m_axi_rvalid);
    tmo_fire = busy && !progress && (wait_q == TW'(TIMEOUT_CYCLES - 1));
    wait_d   = (!busy || progress || tmo_fire) ? '0 : wait_q + 1'b1;
    rsp_timeout_d = rsp_timeout_q;
    if (tmo_fire) begin
      rsp_timeout_d = 1'b1;
    end else if (cmd_valid && cmd_ready_q) begin
      rsp_timeout_d = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wait_q        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign tmo_fire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
